// File: rtl/tc_reg_arb_pkg.sv
// Shared definitions for the register-bus arbiter: requester count, address
// width, round-robin pointer type and a one-hot to index helper.
package tc_reg_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 3;
  localparam int PTR_W   = $clog2(NUM_REQ);

  // Index of the most recently granted requester; the search starts one past it.
  typedef logic [PTR_W-1:0] rr_ptr_t;

  // Resetting to the last index makes requester 0 the first candidate.
  localparam rr_ptr_t PTR_RESET = rr_ptr_t'(NUM_REQ - 1);

  function automatic rr_ptr_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    rr_ptr_t idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = rr_ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Round-robin one-hot picker: scans the request mask starting at the entry
// after ptr and returns the first set bit as a one-hot winner.
module tc_rr_pick
  import tc_reg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_mask,
  input  rr_ptr_t            ptr,
  output logic [NUM_REQ-1:0] winner
);

  rr_ptr_t idx;
  logic    found;

  // NOTE: every output of this block is assigned a default before the loop,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ptr + rr_ptr_t'(k);
      if (!found && req_mask[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc_reg_bus_arbiter.sv
// Four-requester round-robin arbiter in front of a small register file.
// Optional macro TC_REG_ARB_LOCK_EN adds a per-requester lock input.
module tc_reg_bus_arbiter
  import tc_reg_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REGS  = 8,
  parameter int UUID      = 0,
  parameter     NAME      = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           we,
  input  logic [NUM_REQ*ADDR_W-1:0]    addr,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] wdata,
`ifdef TC_REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           lock,
`endif
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [BIT_WIDTH-1:0]         rdata,
  output logic                         busy
);

  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
  rr_ptr_t              ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0] regs_q [NUM_REGS];
  logic [BIT_WIDTH-1:0] regs_d [NUM_REGS];

  logic [NUM_REQ-1:0]   pick;
  logic                 hold;
  rr_ptr_t              sel;
  logic                 acc_we;
  logic [ADDR_W-1:0]    acc_addr;
  logic [BIT_WIDTH-1:0] acc_wdata;

  // The requester holding the grant is masked out so a held req is not served twice.
  tc_rr_pick u_pick (
    .req_mask (req & ~gnt_q),
    .ptr      (ptr_q),
    .winner   (pick)
  );

`ifdef TC_REG_ARB_LOCK_EN
  assign hold = |(gnt_q & lock);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    gnt_d = hold ? gnt_q : pick;
    ptr_d = ptr_q;
    if (|gnt_d) ptr_d = onehot_to_idx(gnt_d);
  end

  // Operands of the access performed at the edge that closes the grant cycle.
  assign sel       = onehot_to_idx(gnt_q);
  assign acc_we    = we[sel];
  assign acc_addr  = addr[int'(sel)*ADDR_W +: ADDR_W];
  assign acc_wdata = wdata[int'(sel)*BIT_WIDTH +: BIT_WIDTH];

  // Addresses at or above NUM_REGS match no entry: saves drop, loads read zero.
  always_comb begin
    regs_d   = regs_q;
    rvalid_d = '0;
    rdata_d  = '0;
    if (|gnt_q) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (acc_addr == ADDR_W'(r)) begin
          if (acc_we) regs_d[r] = acc_wdata;
          else        rdata_d   = regs_q[r];
        end
      end
      if (!acc_we) rvalid_d = gnt_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      ptr_q    <= PTR_RESET;
      // NOTE: the register file must read zero after reset, so unlike a plain
      // RAM it is cleared entry by entry here.
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ptr_q    <= ptr_d;
      regs_q   <= regs_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = |gnt_q;

endmodule
